// File: rtl/mem_burst_arbiter_if.sv
// Requester-side bundle for mem_burst_arbiter: two request/burst ports plus shared read return.
// The master modport is the requester view; slave is the arbiter view.
interface mem_burst_arbiter_if #(
  parameter int DEPTH = 32,
  parameter int BITS  = 64,
  parameter int LEN_W = 3
);
  localparam int AW = $clog2(DEPTH);

  logic             req0, req1;
  logic             we0, we1;
  logic [AW-1:0]    addr0, addr1;
  logic [LEN_W-1:0] len0, len1;
  logic [BITS-1:0]  wdata0, wdata1;
  logic             gnt0, gnt1;
  logic             ack0, ack1;
  logic [BITS-1:0]  rdata;
  logic             rvalid0, rvalid1;
  logic             busy;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, len0, len1, wdata0, wdata1,
    input  gnt0, gnt1, ack0, ack1, rdata, rvalid0, rvalid1, busy
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, len0, len1, wdata0, wdata1,
    output gnt0, gnt1, ack0, ack1, rdata, rvalid0, rvalid1, busy
  );
endinterface

// File: rtl/mem_burst_arbiter.sv
// Two-port round-robin arbiter and burst sequencer in front of a single-port memory
// with combinational read and falling-edge write.
module mem_burst_arbiter #(
  parameter int DEPTH = 32,
  parameter int BITS  = 64,
  parameter int LEN_W = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  mem_burst_arbiter_if.slave       bus,
  output logic [$clog2(DEPTH)-1:0] mem_address,
  output logic [BITS-1:0]          mem_writeData,
  output logic                     mem_writeEn,
  input  logic [BITS-1:0]          mem_readData
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, BURST} state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             ptr_q, ptr_d;
  logic             cur_we_q, cur_we_d;
  logic [AW-1:0]    cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0] beats_left_q, beats_left_d;
  logic [BITS-1:0]  rdata_q, rdata_d;
  logic             rvalid0_q, rvalid0_d;
  logic             rvalid1_q, rvalid1_d;
  logic             winner;
  logic             in_burst;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    ptr_d        = ptr_q;
    cur_we_d     = cur_we_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    rdata_d      = rdata_q;
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;
    // A lone requester wins outright; a tie goes to the priority pointer.
    winner       = (bus.req0 && bus.req1) ? ptr_q : bus.req1;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          owner_d      = winner;
          cur_we_d     = winner ? bus.we1   : bus.we0;
          cur_addr_d   = winner ? bus.addr1 : bus.addr0;
          beats_left_d = winner ? bus.len1  : bus.len0;
          state_d      = BURST;
        end
      end
      BURST: begin
        cur_addr_d   = (cur_addr_q == AW'(DEPTH - 1)) ? '0 : cur_addr_q + AW'(1);
        beats_left_d = beats_left_q - LEN_W'(1);
        if (!cur_we_q) begin
          rdata_d   = mem_readData;
          rvalid0_d = ~owner_q;
          rvalid1_d = owner_q;
        end
        if (beats_left_q == '0) begin
          state_d = IDLE;
          ptr_d   = ~owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_burst      = (state_q == BURST);
  assign bus.busy      = in_burst;
  assign bus.gnt0      = in_burst & ~owner_q;
  assign bus.gnt1      = in_burst & owner_q;
  // ack and write enable are killed by reset in the same cycle so no beat lands.
  assign bus.ack0      = in_burst & ~owner_q & ~reset;
  assign bus.ack1      = in_burst & owner_q & ~reset;
  assign mem_writeEn   = in_burst & cur_we_q & ~reset;
  assign mem_address   = in_burst ? cur_addr_q : '0;
  assign mem_writeData = in_burst ? (owner_q ? bus.wdata1 : bus.wdata0) : '0;
  assign bus.rdata     = rdata_q;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      ptr_q     <= 1'b0;
      rdata_q   <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      rdata_q   <= rdata_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  // Burst context is only meaningful while in BURST, so it carries no reset.
  always_ff @(posedge clk) begin
    cur_we_q     <= cur_we_d;
    cur_addr_q   <= cur_addr_d;
    beats_left_q <= beats_left_d;
  end
endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Bench for mem_burst_arbiter: transaction-level model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_burst_arbiter;
  localparam int DEPTH = 32;
  localparam int BITS  = 64;
  localparam int LEN_W = 3;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_burst_arbiter_if #(.DEPTH(DEPTH), .BITS(BITS), .LEN_W(LEN_W)) bus ();

  logic [AW-1:0]   mem_address;
  logic [BITS-1:0] mem_writeData;
  logic            mem_writeEn;
  logic [BITS-1:0] mem_readData;

  mem_burst_arbiter #(.DEPTH(DEPTH), .BITS(BITS), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_writeEn(mem_writeEn), .mem_readData(mem_readData)
  );

  // Memory the DUT drives, and the model's own copy.
  logic [BITS-1:0] mem     [DEPTH];
  logic [BITS-1:0] ref_mem [DEPTH];
  assign mem_readData = mem[mem_address];
  always @(negedge clk) if (mem_writeEn) mem[mem_address] = mem_writeData;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction model: one burst at a time, beat address = (start + beat) mod DEPTH.
  bit m_active = 0, m_owner = 0, m_we = 0, m_ptr = 0, m_rv0 = 0, m_rv1 = 0;
  int m_start = 0, m_len = 0, m_beat = 0;
  logic [BITS-1:0] m_rdata = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_active = 0; m_ptr = 0; m_rv0 = 0; m_rv1 = 0; m_rdata = '0;
    end else begin
      m_rv0 = 0; m_rv1 = 0;
      if (m_active) begin
        if (!m_we) begin
          m_rdata = ref_mem[(m_start + m_beat) % DEPTH];
          if (m_owner) m_rv1 = 1; else m_rv0 = 1;
        end
        if (m_beat == m_len) begin
          m_active = 0;
          m_ptr    = !m_owner;
        end else m_beat++;
      end else if (bus.req0 || bus.req1) begin
        m_owner  = (bus.req0 && bus.req1) ? m_ptr : bus.req1;
        m_we     = m_owner ? bus.we1 : bus.we0;
        m_start  = m_owner ? int'(bus.addr1) : int'(bus.addr0);
        m_len    = m_owner ? int'(bus.len1) : int'(bus.len0);
        m_beat   = 0;
        m_active = 1;
      end
    end
  end

  always @(negedge clk)
    if (m_active && m_we && !reset)
      ref_mem[(m_start + m_beat) % DEPTH] = m_owner ? bus.wdata1 : bus.wdata0;

  // Write data source: base + beats already acknowledged.
  logic [BITS-1:0] wbase0 = '0, wbase1 = '0;
  int  bcnt0 = 0, bcnt1 = 0;
  bit  a0_prev = 0, a1_prev = 0;
  always begin
    @(posedge clk);
    #1;
    if (a0_prev) bcnt0++;
    if (a1_prev) bcnt1++;
    bus.wdata0 = wbase0 + BITS'(bcnt0);
    bus.wdata1 = wbase1 + BITS'(bcnt1);
    #3;
    a0_prev = bus.ack0;
    a1_prev = bus.ack1;
  end

  // Per-cycle compare plus capture for the directed checks.
  bit chk_en = 0;
  int cyc = 0, last_ack0 = -1, gnt1_rise = -1, n_ack0 = 0, n_ack1 = 0, n_gnt1 = 0;
  bit g1_prev = 0;
  logic [BITS-1:0] rq0[$], rq1[$];
  logic [AW-1:0]   waq[$];

  always @(posedge clk) begin
    #4;
    if (chk_en) begin
      cyc++;
      chk("gnt0", bus.gnt0, m_active && !m_owner);
      chk("gnt1", bus.gnt1, m_active && m_owner);
      chk("ack0", bus.ack0, m_active && !m_owner && !reset);
      chk("ack1", bus.ack1, m_active && m_owner && !reset);
      chk("busy", bus.busy, m_active);
      chk("mem_address", mem_address, m_active ? (m_start + m_beat) % DEPTH : 0);
      chk("mem_writeEn", mem_writeEn, m_active && m_we && !reset);
      if (m_active && m_we && !reset)
        chk("mem_writeData", mem_writeData, m_owner ? bus.wdata1 : bus.wdata0);
      chk("rvalid0", bus.rvalid0, m_rv0);
      chk("rvalid1", bus.rvalid1, m_rv1);
      chk("rdata", bus.rdata, m_rdata);
      if (bus.ack0) begin last_ack0 = cyc; n_ack0++; end
      if (bus.ack1) n_ack1++;
      if (bus.gnt1) n_gnt1++;
      if (bus.gnt1 && !g1_prev) gnt1_rise = cyc;
      g1_prev = bus.gnt1;
      if (bus.rvalid0) rq0.push_back(bus.rdata);
      if (bus.rvalid1) rq1.push_back(bus.rdata);
      if (mem_writeEn) waq.push_back(mem_address);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic burst(input bit port, input bit we, input int addr, input int len,
                       input logic [BITS-1:0] base);
    bit seen = 0;
    bit g = 1;
    if (port) begin
      wbase1 = base; bcnt1 = 0;
      bus.req1 = 1; bus.we1 = we; bus.addr1 = AW'(addr); bus.len1 = LEN_W'(len);
    end else begin
      wbase0 = base; bcnt0 = 0;
      bus.req0 = 1; bus.we0 = we; bus.addr0 = AW'(addr); bus.len0 = LEN_W'(len);
    end
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = port ? bus.gnt1 : bus.gnt0;
    end
    chk("burst_gnt_rise", seen, 1);
    if (port) bus.req1 = 0; else bus.req0 = 0;
    for (int i = 0; i < 40 && g; i++) begin
      tick();
      g = port ? bus.gnt1 : bus.gnt0;
    end
    chk("burst_gnt_fall", g, 0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 64'h1000 + 64'(i);
      ref_mem[i] = 64'h1000 + 64'(i);
    end
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.len0 = '0; bus.len1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
    reset = 1;
    tick(); tick();
    chk("rst_gnt0", bus.gnt0, 0);
    chk("rst_gnt1", bus.gnt1, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rvalid0", bus.rvalid0, 0);
    chk("rst_rvalid1", bus.rvalid1, 0);
    chk("rst_rdata", bus.rdata, 0);
    reset = 0;
    chk_en = 1;

    // Simultaneous requests out of reset, then alternation.
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 5'd0; bus.len0 = 3'd1;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 5'd8; bus.len1 = 3'd1;
    tick();
    chk("sim_gnt0_first", bus.gnt0, 1);
    chk("sim_gnt1_waits", bus.gnt1, 0);
    bus.req0 = 0;
    tick();
    chk("sim_gnt0_beat2", bus.gnt0, 1);
    tick();
    chk("sim_idle_gap", {bus.gnt0, bus.gnt1, bus.busy}, 3'b000);
    bus.req0 = 1; bus.addr0 = 5'd2; bus.len0 = 3'd0;
    tick();
    chk("alt_gnt1_wins", {bus.gnt0, bus.gnt1}, 2'b01);
    bus.req1 = 0;
    tick();
    chk("alt_gnt1_beat2", bus.gnt1, 1);
    tick();
    chk("alt_idle_gap", {bus.gnt0, bus.gnt1}, 2'b00);
    tick();
    chk("alt_gnt0_next", bus.gnt0, 1);
    bus.req0 = 0;
    tick();
    tick();

    // Write 4 beats at addr 4, then read them back.
    n_ack0 = 0;
    burst(0, 1, 4, 3, 64'hA0);
    chk("wr_ack0_beats", n_ack0, 4);
    for (int i = 0; i < 4; i++) chk("wr_mem", mem[4 + i], 64'hA0 + 64'(i));
    chk("model_ref_mem7", ref_mem[7], 64'hA3);
    rq0.delete();
    burst(0, 0, 4, 3, 64'h0);
    chk("rd_count", rq0.size(), 4);
    for (int i = 0; i < 4 && i < rq0.size(); i++) chk("rd_data", rq0[i], 64'hA0 + 64'(i));

    // Address wrap on a port-1 write.
    waq.delete();
    burst(1, 1, 30, 3, 64'h50);
    chk("wrap_count", waq.size(), 4);
    if (waq.size() == 4) begin
      chk("wrap_a0", waq[0], 30);
      chk("wrap_a1", waq[1], 31);
      chk("wrap_a2", waq[2], 0);
      chk("wrap_a3", waq[3], 1);
    end
    chk("wrap_mem30", mem[30], 64'h50);
    chk("wrap_mem31", mem[31], 64'h51);
    chk("wrap_mem0", mem[0], 64'h52);
    chk("wrap_mem1", mem[1], 64'h53);

    // Single-beat read on port 1.
    rq1.delete(); n_gnt1 = 0; n_ack1 = 0;
    burst(1, 0, 9, 0, 64'h0);
    chk("single_gnt1_cycles", n_gnt1, 1);
    chk("single_ack1_cycles", n_ack1, 1);
    chk("single_rd_count", rq1.size(), 1);
    if (rq1.size() == 1) chk("single_rd_data", rq1[0], 64'h1009);

    // Port 1 requests while port 0 runs a 4-beat burst.
    rq1.delete(); gnt1_rise = -1; last_ack0 = -1;
    wbase0 = 64'hC0; bcnt0 = 0;
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 5'd16; bus.len0 = 3'd3;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = bus.gnt0; end
    chk("cont_gnt0", seen, 1);
    bus.req0 = 0;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 5'd16; bus.len1 = 3'd1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = bus.gnt1; end
    chk("cont_gnt1", seen, 1);
    bus.req1 = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("cont_gap", gnt1_rise - last_ack0, 2);
    chk("cont_rd_count", rq1.size(), 2);
    if (rq1.size() == 2) begin
      chk("cont_rd0", rq1[0], 64'hC0);
      chk("cont_rd1", rq1[1], 64'hC1);
    end

    // Reset during the fourth beat of an 8-beat write at addr 0.
    wbase0 = 64'hE0; bcnt0 = 0;
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 5'd0; bus.len0 = 3'd7;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = bus.gnt0; end
    chk("rstb_gnt0", seen, 1);
    bus.req0 = 0;
    tick(); tick(); tick();
    reset = 1;
    #2;
    chk("rstb_writeEn_gated", mem_writeEn, 0);
    chk("rstb_ack0_gated", bus.ack0, 0);
    tick();
    reset = 0;
    chk("rstb_gnt", {bus.gnt0, bus.gnt1}, 2'b00);
    chk("rstb_busy", bus.busy, 0);
    chk("rstb_rvalid", {bus.rvalid0, bus.rvalid1}, 2'b00);
    tick();
    for (int i = 0; i < 3; i++) chk("rstb_mem_written", mem[i], 64'hE0 + 64'(i));
    chk("rstb_mem3_kept", mem[3], 64'h1003);
    for (int i = 4; i < 8; i++) chk("rstb_mem_kept", mem[i], 64'hA0 + 64'(i - 4));
    tick();

    for (int i = 0; i < DEPTH; i++) chk("final_mem", mem[i], ref_mem[i]);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_burst_arbiter.md
Name: mem_burst_arbiter

Overview:
- Two-requester round-robin arbiter and burst sequencer in front of the single-port data memory (DEPTH x BITS, combinational read, write committed on falling clock edge).
- Typical requesters: the SIMD AES vector load/store unit (port 0) and the host/key loader (port 1).
- Serialises word bursts with auto-incrementing, wrapping addresses.
- Drives the memory's address/writeData/writeEn and returns registered read data.

Parameters:
- DEPTH, 32, memory words; address width AW = $clog2(DEPTH).
- BITS, 64, word width.
- LEN_W, 3, burst length field width; burst = len+1 words (1..2^LEN_W).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0 / req1  in  1  request, level; held until gnt of that port rises.
- we0 / we1  in  1  1 = write burst, 0 = read burst; sampled with req.
- addr0 / addr1  in  AW  burst start address; sampled with req.
- len0 / len1  in  LEN_W  beats minus one; sampled with req.
- wdata0 / wdata1  in  BITS  write data for the current beat; must be valid in every cycle ack is high.
- gnt0 / gnt1  out  1  high for the whole burst owned by that port.
- ack0 / ack1  out  1  one pulse per beat executed this cycle.
- rdata  out  BITS  registered read data, shared by both ports.
- rvalid0 / rvalid1  out  1  rdata valid for that port, one cycle after the read beat's ack.
- busy  out  1  high while in BURST.
- mem_address  out  AW  to memory address.
- mem_writeData  out  BITS  to memory writeData.
- mem_writeEn  out  1  to memory writeEn.
- mem_readData  in  BITS  from memory readData.

Behaviour:
- FSM states: IDLE, BURST.
- Reset values: state=IDLE, gnt*=0, rvalid*=0, rdata=0, busy=0, priority pointer=port 0.
- IDLE:
  - Any req high at a rising edge: the winner's we/addr/len are latched (cur_we, cur_addr, beats_left=len) and its gnt goes high; state goes to BURST.
  - Arbitration: one request wins outright. With both high, the port indicated by the priority pointer wins.
  - Pointer update: after each completed burst, the pointer points to the other port.
- BURST, every cycle:
  - mem_address=cur_addr.
  - ack<owner>=1.
  - Write burst: mem_writeData=wdata<owner> (combinational pass-through) and mem_writeEn=cur_we, so the write commits on that cycle's falling edge.
- BURST, at each rising edge:
  - cur_addr increments modulo DEPTH, so DEPTH-1 wraps to 0.
  - For a read beat: rdata<=mem_readData and rvalid<owner> is set for one cycle.
  - beats_left decrements. On the beat where beats_left==0, state returns to IDLE, gnt drops and the pointer toggles.
- Outside BURST: mem_writeEn=0, ack*=0, mem_address=0, mem_writeData=0.
- Timing:
  - Request accepted at edge N: gnt and first beat in cycle N+1; first rvalid in cycle N+2.
  - Back-to-back bursts always have one IDLE cycle between them (arbitration cycle).
- Request handling during a burst:
  - req of the granted port is ignored during its burst.
  - A req still high when IDLE is re-entered is treated as a new request. Requesters drop req once gnt is seen.
  - Another port's req during BURST waits, with no loss.
- Reset mid-burst:
  - mem_writeEn and ack* are gated with ~reset combinationally, so no write occurs in the reset cycle.
  - Next edge: IDLE, all outputs at reset values, in-flight burst discarded, pointer to port 0.
- len=0 gives a single-beat burst. Max burst is 2^LEN_W beats.

Test Plan:
- Write then read: req0, we0=1, addr0=4, len0=3, wdata=beat index+0xA0 → ack0 high cycles 1-4, mem[4..7]=0xA0..0xA3. Then req0 read addr 4 len 3 → rvalid0 cycles 2-5, rdata 0xA0..0xA3.
- Simultaneous requests out of reset: req0 and req1 high in the same cycle, both len=1 → port 0 served first (gnt0 two cycles), one IDLE cycle, then gnt1. Repeating both requests again → port 1 first (alternation).
- Wrap-around: write burst at addr=30, len=3 → mem_address sequence 30, 31, 0, 1, data lands at those four addresses.
- Single beat: req1 read, addr=9, len=0 → gnt1 and ack1 for exactly one cycle, rvalid1 the following cycle with mem[9].
- Reset mid-burst: write burst addr 0, len 7, reset high during beat 3 → mem[0..2] written, mem[3..7] unchanged, mem_writeEn=0 in the reset cycle. Next cycle: gnt*=0, busy=0, rvalid*=0.
- Contention during burst: req1 asserted while port 0 is in a 4-beat burst → gnt1 rises exactly two cycles after the last ack0, with no ack1 during port 0's burst.
